// File: rtl/cia_tod_ctrl_pkg.sv
// Shared types and constants for the CIA time-of-day controller.
// Holds the packed BCD time record and the single-digit BCD increment rule.
package cia_tod_ctrl_pkg;

  typedef struct packed {
    logic       pm;
    logic [4:0] hr;
    logic [6:0] min;
    logic [6:0] sec;
    logic [3:0] tenths;
  } tod_t;

  typedef enum logic {ST_RUN, ST_HALT} halt_e;
  typedef enum logic {ST_LIVE, ST_LATCHED} latch_e;

  localparam logic [1:0] RS_TENTHS = 2'd0;
  localparam logic [1:0] RS_SEC    = 2'd1;
  localparam logic [1:0] RS_MIN    = 2'd2;
  localparam logic [1:0] RS_HR     = 2'd3;

  localparam logic [2:0] PRESC_60 = 3'd5;
  localparam logic [2:0] PRESC_50 = 3'd4;

  localparam tod_t TOD_RESET = '{pm: 1'b0, hr: 5'h01, min: 7'h00, sec: 7'h00, tenths: 4'h0};
  localparam tod_t TOD_ZERO  = '{pm: 1'b0, hr: 5'h00, min: 7'h00, sec: 7'h00, tenths: 4'h0};

  // {carry, digit}: 9 rolls to 0 with carry, anything else is a plain 4-bit +1.
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d);
    if (d == 4'd9) return 5'b1_0000;
    return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/cia_tod_ctrl_bcd.sv
// Two-digit BCD field incrementer with terminal value; used for seconds and minutes.
module cia_tod_ctrl_bcd
  import cia_tod_ctrl_pkg::*;
#(
  parameter int W = 7
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] max,
  input  logic         carry_in,
  output logic [W-1:0] next,
  output logic         carry_out
);

  logic [4:0] lo;

  always_comb begin
    next      = value;
    carry_out = 1'b0;
    lo        = bcd_digit_inc(value[3:0]);
    if (carry_in) begin
      if (value == max) begin
        next      = '0;
        carry_out = 1'b1;
      end else begin
        next[3:0] = lo[3:0];
        if (lo[4]) next[W-1:4] = value[W-1:4] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cia_tod_ctrl.sv
// CIA TOD controller: edge prescaler, BCD time-of-day counter, write-halt,
// read-latch and alarm-match interrupt.
module cia_tod_ctrl
  import cia_tod_ctrl_pkg::*;
#(
  parameter logic [7:0] RESET_HR = 8'h01
) (
  input  logic       clk,
  input  logic       res,
  input  logic       phi2_up,
  input  logic       tod_edge,
  input  logic       todin,
  input  logic       alarm_sel,
  input  logic [1:0] rs,
  input  logic       bus_we,
  input  logic       bus_re,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       irq_alarm
);

  localparam tod_t TIME_INIT = '{pm: RESET_HR[7], hr: RESET_HR[4:0], min: TOD_RESET.min,
                                 sec: TOD_RESET.sec, tenths: TOD_RESET.tenths};

  tod_t       time_r, alarm_r, snap_r;
  tod_t       time_nx, alarm_nx, src;
  logic [2:0] presc;
  halt_e      halt_st;
  latch_e     latch_st;

  logic       time_wr, alarm_wr, presc_adv, presc_term, tick, latch_take;
  logic [4:0] ten_inc, hr_lo;
  logic [6:0] sec_nx, min_nx;
  logic       sec_c, min_c;
  logic [4:0] hr_nx;
  logic       pm_nx;

  function automatic tod_t write_field(input tod_t t, input logic [1:0] sel,
                                       input logic [7:0] d);
    tod_t r = t;
    case (sel)
      RS_TENTHS: r.tenths = d[3:0];
      RS_SEC:    r.sec    = d[6:0];
      RS_MIN:    r.min    = d[6:0];
      default: begin
        r.hr = d[4:0];
        r.pm = d[7];
      end
    endcase
    return r;
  endfunction

  assign time_wr    = bus_we & ~alarm_sel;
  assign alarm_wr   = bus_we & alarm_sel;
  assign presc_adv  = phi2_up & tod_edge & (halt_st == ST_RUN);
  assign presc_term = (presc == (todin ? PRESC_50 : PRESC_60));
  // A register write in the same cycle swallows the tick rather than deferring it.
  assign tick       = presc_adv & presc_term & ~time_wr;
  assign latch_take = bus_re & (rs == RS_HR) & (latch_st == ST_LIVE);
  assign ten_inc    = bcd_digit_inc(time_r.tenths);

  cia_tod_ctrl_bcd #(.W(7)) u_sec (
    .value    (time_r.sec),
    .max      (7'h59),
    .carry_in (tick & ten_inc[4]),
    .next     (sec_nx),
    .carry_out(sec_c)
  );

  cia_tod_ctrl_bcd #(.W(7)) u_min (
    .value    (time_r.min),
    .max      (7'h59),
    .carry_in (sec_c),
    .next     (min_nx),
    .carry_out(min_c)
  );

  // 12-hour sequence: 11->12 flips AM/PM, 12->01, otherwise a BCD step.
  always_comb begin
    hr_nx = time_r.hr;
    pm_nx = time_r.pm;
    hr_lo = bcd_digit_inc(time_r.hr[3:0]);
    if (min_c) begin
      if (time_r.hr == 5'h12) begin
        hr_nx = 5'h01;
      end else if (time_r.hr == 5'h11) begin
        hr_nx = 5'h12;
        pm_nx = ~time_r.pm;
      end else begin
        hr_nx[3:0] = hr_lo[3:0];
        if (hr_lo[4]) hr_nx[4] = ~time_r.hr[4];
      end
    end
  end

  always_comb begin
    time_nx  = time_r;
    alarm_nx = alarm_r;
    if (tick) begin
      time_nx.tenths = ten_inc[3:0];
      time_nx.sec    = sec_nx;
      time_nx.min    = min_nx;
      time_nx.hr     = hr_nx;
      time_nx.pm     = pm_nx;
    end
    if (time_wr)  time_nx  = write_field(time_r, rs, data_i);
    if (alarm_wr) alarm_nx = write_field(alarm_r, rs, data_i);
  end

  always_comb begin
    src = (latch_st == ST_LATCHED) ? snap_r : time_r;
    case (rs)
      RS_TENTHS: data_o = {4'h0, src.tenths};
      RS_SEC:    data_o = {1'b0, src.sec};
      RS_MIN:    data_o = {1'b0, src.min};
      default:   data_o = {src.pm, 2'b00, src.hr};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      time_r    <= TIME_INIT;
      alarm_r   <= TOD_ZERO;
      presc     <= 3'd0;
      halt_st   <= ST_HALT;
      latch_st  <= ST_LIVE;
      irq_alarm <= 1'b0;
    end else begin
      time_r  <= time_nx;
      alarm_r <= alarm_nx;

      if (time_wr && rs == RS_TENTHS) presc <= 3'd0;
      else if (presc_adv)             presc <= presc_term ? 3'd0 : presc + 3'd1;

      if (time_wr && rs == RS_HR)          halt_st <= ST_HALT;
      else if (time_wr && rs == RS_TENTHS) halt_st <= ST_RUN;

      case (latch_st)
        ST_LIVE:    if (latch_take) latch_st <= ST_LATCHED;
        ST_LATCHED: if (bus_re && rs == RS_TENTHS) latch_st <= ST_LIVE;
        default:    latch_st <= ST_LIVE;
      endcase

      // Compare the values that become visible next cycle, so the pulse lands one clk after the change.
      irq_alarm <= (tick | bus_we) & (time_nx == alarm_nx);
    end
  end

  always_ff @(posedge clk) begin
    if (latch_take) snap_r <= time_r;
  end

endmodule
